// File: rtl/adc_sar_multi.sv
`default_nettype none
// ============================================================================
// adc_sar_multi : multi-channel RC/comparator SAR ADC sequencer with averaging
// Revision      : 1.0
// ============================================================================
module adc_sar_multi #(
  parameter int          CHANNELS         = 2,
  parameter int          RES_BITS         = 8,
  parameter int          AVG_LOG2         = 0,
  parameter logic [15:0] HALF_CHARGE_TIME = 16'd130,
  parameter logic [15:0] DISCHARGE_TIME   = 16'd255
) (
  input  logic                                             CLK,
  input  logic                                             RESET,
  input  logic                                             ENABLE,
  input  logic [CHANNELS-1:0]                              comp_in,
  output logic [CHANNELS-1:0]                              RC_CNTL,
  output logic [RES_BITS-1:0]                              DATA_OUT,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CHAN_OUT,
  output logic                                             DATA_VALID,
  output logic [CHANNELS*RES_BITS-1:0]                     DATA_ALL
);

  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW     = $clog2(RES_BITS);
  localparam int AW     = RES_BITS + AVG_LOG2;
  localparam int PASSES = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DISCHARGE = 2'd1,
    S_CONVERT   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic [15:0]                  step_q, step_d;
  logic [BW-1:0]                bit_q, bit_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [3:0]                   pass_q, pass_d;
  logic [AW-1:0]                acc_q, acc_d;
  logic [RES_BITS-1:0]          code_q, code_d;
  logic [CHANNELS-1:0]          rc_q, rc_d;
  logic [RES_BITS-1:0]          data_q, data_d;
  logic [CHANNELS*RES_BITS-1:0] all_q, all_d;
  logic [CW-1:0]                chan_q, chan_d;
  logic                         valid_q, valid_d;

  logic                         comp_bit;
  logic [RES_BITS-1:0]          code_full;
  logic [AW-1:0]                acc_sum;
  logic [RES_BITS-1:0]          avg;
  logic                         last_pass;
  logic                         last_chan;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    bit_d     = bit_q;
    ch_d      = ch_q;
    pass_d    = pass_q;
    acc_d     = acc_q;
    code_d    = code_q;
    rc_d      = rc_q;
    data_d    = data_q;
    all_d     = all_q;
    chan_d    = chan_q;
    valid_d   = 1'b0;

    // The code including the bit being sampled this edge feeds the accumulator.
    comp_bit         = comp_in[ch_q];
    code_full        = code_q;
    code_full[bit_q] = comp_bit;
    acc_sum          = acc_q + AW'(code_full);
    avg              = RES_BITS'(acc_sum >> AVG_LOG2);
    last_pass        = (pass_q == 4'(PASSES - 1));
    last_chan        = (ch_q == CW'(CHANNELS - 1));

    case (state_q)
      S_IDLE: begin
        rc_d = '0;
        if (ENABLE) begin
          state_d = S_DISCHARGE;
          cnt_d   = DISCHARGE_TIME;
        end
      end

      S_DISCHARGE: begin
        rc_d = '0;
        if (cnt_q == 16'd0) begin
          state_d    = S_CONVERT;
          rc_d[ch_q] = 1'b1;
          cnt_d      = HALF_CHARGE_TIME;
          step_d     = HALF_CHARGE_TIME;
          bit_d      = BW'(RES_BITS - 1);
          code_d     = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_CONVERT: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          code_d     = code_full;
          step_d     = step_q >> 1;
          cnt_d      = step_q >> 1;
          rc_d[ch_q] = comp_bit;
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else begin
            rc_d    = '0;
            state_d = S_DISCHARGE;
            cnt_d   = DISCHARGE_TIME;
            if (last_pass) begin
              acc_d   = '0;
              pass_d  = '0;
              data_d  = avg;
              all_d[int'(ch_q)*RES_BITS +: RES_BITS] = avg;
              chan_d  = ch_q;
              valid_d = 1'b1;
              ch_d    = last_chan ? '0 : ch_q + CW'(1);
              if (!ENABLE) state_d = S_IDLE;
            end else begin
              acc_d  = acc_sum;
              pass_d = pass_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        rc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      pass_q  <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      rc_q    <= '0;
      data_q  <= '0;
      all_q   <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      pass_q  <= pass_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      rc_q    <= rc_d;
      data_q  <= data_d;
      all_q   <= all_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign RC_CNTL    = rc_q;
  assign DATA_OUT   = data_q;
  assign CHAN_OUT   = chan_q;
  assign DATA_VALID = valid_q;
  assign DATA_ALL   = all_q;

endmodule
`default_nettype wire

// File: doc/adc_sar_multi.md
ADC_SAR_MULTI -- requirements
Module: adc_sar_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, range 1..8: number of RC/comparator channels scanned.
REQ-002 SHALL have parameter RES_BITS, default 8, range 4..12: conversion resolution.
REQ-003 SHALL have parameter AVG_LOG2, default 0, range 0..3: 2^AVG_LOG2 conversions are averaged per published result.
REQ-004 SHALL have parameter HALF_CHARGE_TIME, default 130, 16-bit: cycles for the MSB charge step.
REQ-005 SHALL have parameter DISCHARGE_TIME, default 255, 16-bit: cycles to discharge the cap before each conversion.
REQ-006 SHALL have port CLK, input, 1 bit: single clock for all logic.
REQ-007 SHALL have port RESET, input, 1 bit: reset is synchronous and active-high.
REQ-008 SHALL have port ENABLE, input, 1 bit: permits starting new conversions.
REQ-009 SHALL have port comp_in, input, CHANNELS bits: per-channel comparator result, already synchronous to CLK.
REQ-010 SHALL have port RC_CNTL, output, CHANNELS bits: per-channel RC charge drive.
REQ-011 SHALL have port DATA_OUT, output, RES_BITS bits: latest published result.
REQ-012 SHALL have port CHAN_OUT, output, clog2(CHANNELS) bits (min 1): channel of DATA_OUT.
REQ-013 SHALL have port DATA_VALID, output, 1 bit: one-cycle pulse marking a new DATA_OUT.
REQ-014 SHALL have port DATA_ALL, output, CHANNELS*RES_BITS bits: per-channel result bank, channel n at bits [n*RES_BITS +: RES_BITS].

Function
REQ-015 SHALL implement states IDLE, DISCHARGE, CONVERT; a step counter (16 bit), charge-step register (16 bit), bit index, channel index and pass counter.
REQ-016 IDLE: all RC_CNTL 0; if ENABLE=1, next edge -> DISCHARGE with counter=DISCHARGE_TIME; else remain.
REQ-017 DISCHARGE: active channel RC_CNTL=0; counter decrements each edge; on the edge with counter==0 -> CONVERT, RC_CNTL[ch]=1, counter=HALF_CHARGE_TIME, step=HALF_CHARGE_TIME, bit index=RES_BITS-1.
REQ-018 CONVERT: counter decrements each edge; on the edge with counter==0: sample_reg[bit]=comp_in[ch], RC_CNTL[ch]=comp_in[ch], step=step>>1, counter=step>>1, bit index decrements.
REQ-019 When step has shifted to 0, each remaining bit SHALL be sampled on consecutive edges (one cycle per bit).
REQ-020 Non-active channels SHALL hold RC_CNTL=0 at all times.
REQ-021 On the edge sampling bit 0: the full code (including that bit) SHALL be added to an accumulator of width RES_BITS+AVG_LOG2 and the pass counter incremented; the accumulator is cleared at each channel start.
REQ-022 On the final pass of a channel, that same edge SHALL latch accumulator>>AVG_LOG2 (truncating) into DATA_OUT and DATA_ALL[ch], set CHAN_OUT=ch, and assert DATA_VALID for exactly one cycle.
REQ-023 After bit 0 the FSM SHALL -> DISCHARGE (counter=DISCHARGE_TIME) for the next pass or next channel, or -> IDLE if the channel is complete and ENABLE=0.
REQ-024 Channel index SHALL advance 0,1,..,CHANNELS-1 and wrap to 0 after all passes complete; CHANNELS=1 stays on 0.
REQ-025 ENABLE deasserted mid-channel SHALL NOT abort it; the channel completes and publishes first.
REQ-026 With AVG_LOG2=0, DATA_OUT SHALL equal the raw SAR code.

Reset
REQ-027 RESET=1 at an edge SHALL force state=IDLE, RC_CNTL=0, DATA_OUT=0, DATA_ALL=0, CHAN_OUT=0, DATA_VALID=0, channel/pass/bit indices and accumulator=0.
REQ-028 RESET SHALL take priority over every in-progress operation, including mid-conversion and the publish edge (no DATA_VALID on that edge).

Verification (CHANNELS=2, RES_BITS=8, HALF_CHARGE_TIME=8, DISCHARGE_TIME=4, AVG_LOG2=0 unless noted)
REQ-029 ENABLE=1, comp_in=2'b11 after reset release -> DATA_VALID first high after the 29th edge, CHAN_OUT=0, DATA_OUT=0xFF; next pulse 28 edges later, CHAN_OUT=1, DATA_OUT=0xFF.
REQ-030 comp_in[0]=1, comp_in[1]=0 -> DATA_ALL=16'h00FF after both channels publish; RC_CNTL[1]=0 throughout channel 0 conversion.
REQ-031 comp_in[0] driven per bit 1,0,1,0,1,0,1,0 (MSB first) -> DATA_OUT=0xAA on channel 0; RC_CNTL[0] follows each sampled bit.
REQ-032 AVG_LOG2=2, channel 0 codes 0xFF,0x00,0xFF,0x00 -> single DATA_VALID after 4th pass, DATA_OUT=0x7F; no pulses on passes 1-3.
REQ-033 RESET pulsed mid-CONVERT on channel 1 -> all outputs 0 next cycle, no DATA_VALID, restart from channel 0 with same 29-edge latency.
REQ-034 ENABLE dropped during channel 0 DISCHARGE -> channel 0 completes and publishes, FSM then IDLE with RC_CNTL=0; ENABLE raised -> resumes at channel 1.
